// File: rtl/oflow_core_seq_ctrl.sv
// Frame/set sequencer for the optical-flow core: splits a frame's bboxes into PE-sized sets,
// then runs either a direct write or conflict resolution + write. OFLOW_CR_WATCHDOG_EN adds a CR timeout.
module oflow_core_seq_ctrl #(
    parameter int unsigned PE_NUM     = 24,
    parameter int unsigned BBOX_W     = 7,
    parameter int unsigned FRAME_W    = 8,
    parameter int unsigned CR_TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        reset_N,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        new_frame,
    input  logic [BBOX_W-1:0]           num_of_bbox_in_frame,
    input  logic                        new_set_from_dma,
    input  logic                        done_pe,
    input  logic                        done_cr,
    input  logic                        conflict_counter_th,
    input  logic                        done_write,
    output logic                        ready_new_frame,
    output logic                        ready_new_set,
    output logic                        start_pe,
    output logic                        start_cr,
    output logic                        start_write_mem,
    output logic                        start_write_score,
    output logic                        valid_id,
    output logic [$clog2(PE_NUM+1)-1:0] pe_count,
    output logic [BBOX_W-1:0]           num_of_sets,
    output logic [BBOX_W-1:0]           set_idx,
    output logic [BBOX_W-1:0]           counter_of_remain_bboxes,
    output logic [FRAME_W-1:0]          frame_num,
    output logic                        busy,
    output logic                        error
);

    localparam int unsigned PC_W = $clog2(PE_NUM + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_FRAME = 3'd1;
    localparam logic [2:0] S_SET_VARS   = 3'd2;
    localparam logic [2:0] S_WAIT_SET   = 3'd3;
    localparam logic [2:0] S_PE         = 3'd4;
    localparam logic [2:0] S_CR         = 3'd5;
    localparam logic [2:0] S_WRITE      = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [BBOX_W-1:0] n_lat;
    logic              cr_timeout;
    logic              more_sets;

`ifdef OFLOW_CR_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(CR_TIMEOUT + 1);
    logic [CNT_W-1:0] cr_cnt;

    // Held at zero outside CR, so it restarts on every CR entry.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N)
            cr_cnt <= '0;
        else if (state != S_CR)
            cr_cnt <= '0;
        else
            cr_cnt <= cr_cnt + CNT_W'(1);
    end

    assign cr_timeout = (state == S_CR) && (cr_cnt == CNT_W'(CR_TIMEOUT - 1));
`else
    assign cr_timeout = 1'b0 && (CR_TIMEOUT != 0);
`endif

    assign busy            = (state != S_IDLE);
    assign ready_new_frame = (state == S_WAIT_FRAME);
    assign ready_new_set   = (state == S_WAIT_SET);
    assign more_sets       = (32'(set_idx) + 1) < 32'(num_of_sets);

    always_comb begin
        state_nx          = state;
        start_pe          = 1'b0;
        start_cr          = 1'b0;
        start_write_mem   = 1'b0;
        start_write_score = 1'b0;
        valid_id          = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state_nx = S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (new_frame && (num_of_bbox_in_frame != '0))
                        state_nx = S_SET_VARS;
                end
                S_SET_VARS: begin
                    state_nx = S_WAIT_SET;
                end
                S_WAIT_SET: begin
                    if (new_set_from_dma) begin
                        start_pe = 1'b1;
                        state_nx = S_PE;
                    end
                end
                S_PE: begin
                    if (done_pe) begin
                        if (more_sets) begin
                            state_nx = S_WAIT_SET;
                        end else if (frame_num == '0) begin
                            start_write_mem   = 1'b1;
                            start_write_score = 1'b1;
                            state_nx          = S_WRITE;
                        end else begin
                            start_cr = 1'b1;
                            state_nx = S_CR;
                        end
                    end
                end
                S_CR: begin
                    if (done_cr) begin
                        start_write_mem   = 1'b1;
                        start_write_score = 1'b1;
                        valid_id          = 1'b1;
                        state_nx          = S_WRITE;
                    end else if (conflict_counter_th || cr_timeout) begin
                        state_nx = S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (done_write)
                        state_nx = S_WAIT_FRAME;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state                    <= S_IDLE;
            n_lat                    <= '0;
            pe_count                 <= '0;
            num_of_sets              <= '0;
            set_idx                  <= '0;
            counter_of_remain_bboxes <= '0;
            frame_num                <= '0;
            error                    <= 1'b0;
        end else begin
            state <= state_nx;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            frame_num <= '0;
                            error     <= 1'b0;
                        end
                    end
                    S_WAIT_FRAME: begin
                        if (new_frame) begin
                            n_lat <= num_of_bbox_in_frame;
                            if (num_of_bbox_in_frame == '0)
                                frame_num <= frame_num + FRAME_W'(1);
                        end
                    end
                    S_SET_VARS: begin
                        num_of_sets              <= BBOX_W'((32'(n_lat) + PE_NUM - 1) / PE_NUM);
                        counter_of_remain_bboxes <= n_lat;
                        set_idx                  <= '0;
                    end
                    S_WAIT_SET: begin
                        if (new_set_from_dma) begin
                            if (32'(counter_of_remain_bboxes) < PE_NUM)
                                pe_count <= PC_W'(counter_of_remain_bboxes);
                            else
                                pe_count <= PC_W'(PE_NUM);
                        end
                    end
                    S_PE: begin
                        if (done_pe) begin
                            counter_of_remain_bboxes <= counter_of_remain_bboxes - BBOX_W'(pe_count);
                            set_idx                  <= set_idx + BBOX_W'(1);
                        end
                    end
                    S_CR: begin
                        if (!done_cr && (conflict_counter_th || cr_timeout))
                            error <= 1'b1;
                    end
                    S_WRITE: begin
                        if (done_write)
                            frame_num <= frame_num + FRAME_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oflow_core_seq_ctrl.sv
// Directed-plus-random bench for oflow_core_seq_ctrl; expectations come from a frame-level model
// (set sizes by arithmetic, frame counter modulo 4). Honours OFLOW_CR_WATCHDOG_EN for the CR timeout step.
module tb_oflow_core_seq_ctrl;

    localparam int PEN     = 24;
    localparam int FMOD    = 4;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset_N;
    logic       start, abort, new_frame, new_set_from_dma;
    logic [6:0] num_of_bbox_in_frame;
    logic       done_pe, done_cr, conflict_counter_th, done_write;
    logic       ready_new_frame, ready_new_set;
    logic       start_pe, start_cr, start_write_mem, start_write_score, valid_id;
    logic [4:0] pe_count;
    logic [6:0] num_of_sets, set_idx, counter_of_remain_bboxes;
    logic [1:0] frame_num;
    logic       busy, error;

    int vectors    = 0;
    int miscompares = 0;
    int m_frame    = 0;
    int m_err      = 0;

    oflow_core_seq_ctrl #(
        .PE_NUM    (PEN),
        .BBOX_W    (7),
        .FRAME_W   (2),
        .CR_TIMEOUT(TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset_N                 (reset_N),
        .start                   (start),
        .abort                   (abort),
        .new_frame               (new_frame),
        .num_of_bbox_in_frame    (num_of_bbox_in_frame),
        .new_set_from_dma        (new_set_from_dma),
        .done_pe                 (done_pe),
        .done_cr                 (done_cr),
        .conflict_counter_th     (conflict_counter_th),
        .done_write              (done_write),
        .ready_new_frame         (ready_new_frame),
        .ready_new_set           (ready_new_set),
        .start_pe                (start_pe),
        .start_cr                (start_cr),
        .start_write_mem         (start_write_mem),
        .start_write_score       (start_write_score),
        .valid_id                (valid_id),
        .pe_count                (pe_count),
        .num_of_sets             (num_of_sets),
        .set_idx                 (set_idx),
        .counter_of_remain_bboxes(counter_of_remain_bboxes),
        .frame_num               (frame_num),
        .busy                    (busy),
        .error                   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_frame = 0;
        m_err   = 0;
        chk("start_busy", 32'(busy), 1);
        chk("start_rdy_frame", 32'(ready_new_frame), 1);
        chk("start_frame_num", 32'(frame_num), 0);
        chk("start_error", 32'(error), 0);
    endtask

    // kind: 0 done_cr, 1 done_cr+threshold, 2 threshold only, 3 withhold done_cr
    task automatic run_frame(input int n, input int kind_in, input int abort_set);
        int  sets, rem, size, kind;
        bit  last;
        kind = kind_in;
        repeat ($urandom_range(0, 2)) begin
            chk("rdy_frame_wait", 32'(ready_new_frame), 1);
            tick();
        end
        chk("rdy_frame", 32'(ready_new_frame), 1);
        new_frame = 1'b1;
        num_of_bbox_in_frame = 7'(n);
        #1 chk("no_pe_on_frame", 32'(start_pe), 0);
        tick();
        new_frame = 1'b0;
        if (n == 0) begin
            m_frame = (m_frame + 1) % FMOD;
            chk("frame_num_empty", 32'(frame_num), 32'(m_frame));
            chk("empty_stays_wait", 32'(ready_new_frame), 1);
            return;
        end
        chk("setvars_no_rdy_set", 32'(ready_new_set), 0);
        chk("setvars_no_rdy_frame", 32'(ready_new_frame), 0);
        tick();
        sets = (n + PEN - 1) / PEN;
        rem  = n;
        chk("num_of_sets", 32'(num_of_sets), 32'(sets));
        chk("remain_init", 32'(counter_of_remain_bboxes), 32'(rem));
        chk("set_idx_init", 32'(set_idx), 0);
        chk("rdy_set", 32'(ready_new_set), 1);
        for (int s = 0; s < sets; s++) begin
            size = (rem < PEN) ? rem : PEN;
            last = (s == sets - 1);
            repeat ($urandom_range(0, 2)) begin
                chk("rdy_set_wait", 32'(ready_new_set), 1);
                chk("no_pe_wait", 32'(start_pe), 0);
                tick();
            end
            new_set_from_dma = 1'b1;
            #1 chk("start_pe", 32'(start_pe), 1);
            tick();
            new_set_from_dma = 1'b0;
            chk("pe_count", 32'(pe_count), 32'(size));
            chk("pe_no_rdy_set", 32'(ready_new_set), 0);
            repeat ($urandom_range(0, 3)) begin
                done_cr             = 1'($urandom_range(0, 1));
                done_write          = 1'($urandom_range(0, 1));
                conflict_counter_th = 1'($urandom_range(0, 1));
                #1;
                chk("stray_start_cr", 32'(start_cr), 0);
                chk("stray_write_mem", 32'(start_write_mem), 0);
                chk("stray_valid_id", 32'(valid_id), 0);
                tick();
                done_cr = 1'b0; done_write = 1'b0; conflict_counter_th = 1'b0;
            end
            done_pe = 1'b1;
            if (s == abort_set) begin
                abort = 1'b1;
                #1;
                chk("abort_no_cr", 32'(start_cr), 0);
                chk("abort_no_write", 32'(start_write_mem), 0);
                tick();
                abort = 1'b0; done_pe = 1'b0;
                chk("abort_idle", 32'(busy), 0);
                chk("abort_frame_held", 32'(frame_num), 32'(m_frame));
                chk("abort_err_held", 32'(error), 32'(m_err));
                return;
            end
            #1;
            chk("start_cr", 32'(start_cr), 32'(last && m_frame != 0));
            chk("pe_write_mem", 32'(start_write_mem), 32'(last && m_frame == 0));
            chk("pe_write_score", 32'(start_write_score), 32'(last && m_frame == 0));
            tick();
            done_pe = 1'b0;
            rem -= size;
            chk("remain", 32'(counter_of_remain_bboxes), 32'(rem));
            chk("set_idx", 32'(set_idx), 32'(s + 1));
        end
        if (m_frame != 0) begin
            if (kind == 3) begin
`ifdef OFLOW_CR_WATCHDOG_EN
                repeat (TIMEOUT - 1) tick();
                chk("wd_still_cr", 32'(busy), 1);
                tick();
                m_err = 1;
                chk("wd_idle", 32'(busy), 0);
                chk("wd_error", 32'(error), 1);
                return;
`else
                repeat (100) tick();
                chk("cr_no_watchdog_busy", 32'(busy), 1);
                chk("cr_no_watchdog_err", 32'(error), 0);
                kind = 0;
`endif
            end
            repeat ($urandom_range(0, 3)) begin
                chk("cr_wait_busy", 32'(busy), 1);
                chk("cr_wait_no_write", 32'(start_write_mem), 0);
                tick();
            end
            done_cr             = (kind != 2);
            conflict_counter_th = (kind != 0);
            #1;
            chk("cr_write_mem", 32'(start_write_mem), 32'(kind != 2));
            chk("cr_write_score", 32'(start_write_score), 32'(kind != 2));
            chk("cr_valid_id", 32'(valid_id), 32'(kind != 2));
            tick();
            done_cr = 1'b0; conflict_counter_th = 1'b0;
            if (kind == 2) begin
                m_err = 1;
                chk("th_idle", 32'(busy), 0);
                chk("th_error", 32'(error), 1);
                return;
            end
            chk("cr_error_clear", 32'(error), 32'(m_err));
        end
        repeat ($urandom_range(0, 3)) begin
            chk("write_wait_busy", 32'(busy), 1);
            tick();
        end
        done_write = 1'b1;
        #1 chk("write_no_valid_id", 32'(valid_id), 0);
        tick();
        done_write = 1'b0;
        m_frame = (m_frame + 1) % FMOD;
        chk("frame_num", 32'(frame_num), 32'(m_frame));
        chk("write_to_wait_frame", 32'(ready_new_frame), 1);
    endtask

    initial begin
        reset_N = 1'b0;
        start = 1'b0; abort = 1'b0; new_frame = 1'b0; new_set_from_dma = 1'b0;
        num_of_bbox_in_frame = '0;
        done_pe = 1'b0; done_cr = 1'b0; conflict_counter_th = 1'b0; done_write = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'({ready_new_frame, ready_new_set}), 0);
        chk("rst_strobes", 32'({start_pe, start_cr, start_write_mem, start_write_score, valid_id}), 0);
        chk("rst_pe_count", 32'(pe_count), 0);
        chk("rst_sets", 32'(num_of_sets), 0);
        chk("rst_set_idx", 32'(set_idx), 0);
        chk("rst_remain", 32'(counter_of_remain_bboxes), 0);
        chk("rst_frame_num", 32'(frame_num), 0);
        chk("rst_error", 32'(error), 0);
        reset_N = 1'b1;
        tick();

        do_start();
        run_frame(50, 0, -1);
        run_frame(24, 0, -1);
        run_frame(30, 1, -1);
        run_frame($urandom_range(1, 127), 0, -1);
        run_frame(0, 0, -1);
        run_frame(40, 2, -1);
        chk("err_no_rdy_frame", 32'(ready_new_frame), 0);

        do_start();
        run_frame(50, 0, -1);
        run_frame(48, 0, 1);
        do_start();

        for (int i = 0; i < 8; i++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            run_frame(n, $urandom_range(0, 1), -1);
        end

        if (m_frame == 0)
            run_frame(0, 0, -1);
        run_frame($urandom_range(1, 127), 3, -1);

        if (!busy)
            do_start();
        new_frame = 1'b1;
        num_of_bbox_in_frame = 7'd60;
        tick();
        new_frame = 1'b0;
        tick();
        #2 reset_N = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_sets", 32'(num_of_sets), 0);
        chk("async_rst_remain", 32'(counter_of_remain_bboxes), 0);
        chk("async_rst_frame", 32'(frame_num), 0);
        chk("async_rst_rdy_set", 32'(ready_new_set), 0);
        #10 reset_N = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
